// File: rtl/l15_store_req_noc_if_if.sv
// rtl/l15_store_req_noc_if_if.sv - request, NoC1, NoC2 and response bundle for the L1.5 store endpoint
interface l15_store_req_noc_if_if;
  logic        req_valid;
  logic        req_ready;
  logic [39:0] req_addr;
  logic [7:0]  req_mshrid;
  logic [2:0]  req_size;

  logic [63:0] noc1_data_out;
  logic        noc1_valid_out;
  logic        noc1_ready_out;

  logic [63:0] noc2_data_in;
  logic        noc2_valid_in;
  logic        noc2_ready_in;

  logic        resp_valid;
  logic [7:0]  resp_type;
  logic [7:0]  resp_mshrid;
  logic [63:0] resp_data;
  logic        resp_error;

  // Endpoint view
  modport master (
    input  req_valid, req_addr, req_mshrid, req_size,
    output req_ready,
    output noc1_data_out, noc1_valid_out,
    input  noc1_ready_out,
    input  noc2_data_in, noc2_valid_in,
    output noc2_ready_in,
    output resp_valid, resp_type, resp_mshrid, resp_data, resp_error
  );

  // MSHR logic / router view
  modport slave (
    output req_valid, req_addr, req_mshrid, req_size,
    input  req_ready,
    input  noc1_data_out, noc1_valid_out,
    output noc1_ready_out,
    output noc2_data_in, noc2_valid_in,
    input  noc2_ready_in,
    input  resp_valid, resp_type, resp_mshrid, resp_data, resp_error
  );
endinterface

// File: rtl/l15_store_req_noc_if.sv
// rtl/l15_store_req_noc_if.sv - L1.5 store request serializer and L2 response matcher
module l15_store_req_noc_if #(
  parameter int         NUM_MSHR       = 8,
  parameter logic [7:0] STORE_REQ_TYPE = 8'd2,
  parameter logic [7:0] MAX_PAYLOAD    = 8'd8
) (
  input  logic                clk,
  input  logic                rst,
  l15_store_req_noc_if_if.master bus,
  input  logic [13:0]         dst_chipid,
  input  logic [7:0]          dst_x,
  input  logic [7:0]          dst_y,
  input  logic [13:0]         src_chipid,
  input  logic [7:0]          src_x,
  input  logic [7:0]          src_y,
  output logic [NUM_MSHR-1:0] busy_vec
);
  localparam int         IDW        = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;
  localparam logic [7:0] NUM_MSHR_B = 8'(NUM_MSHR);

  typedef enum logic [1:0] {IDLE, HDR, ADDR, SRC} tx_state_t;
  typedef enum logic {R_HDR, R_PAY} rx_state_t;

  tx_state_t   tx_state, tx_next;
  logic [39:0] tx_addr;
  logic [7:0]  tx_id;
  logic [2:0]  tx_size;
  logic        req_fire;
  logic        noc1_fire;

  rx_state_t   rx_state;
  logic [7:0]  rx_type, rx_id, rx_len, rx_cnt;
  logic [63:0] rx_data;
  logic        noc2_fire;
  logic        first_pay;

  logic        cmp_fire, cmp_err;
  logic [7:0]  cmp_type, cmp_id, cmp_len;
  logic [63:0] cmp_data;
  logic [NUM_MSHR-1:0] set_vec, clr_vec;

  // Only an idle serializer with a free, in-range slot takes a new store
  assign bus.req_ready = !rst && (tx_state == IDLE) && (bus.req_mshrid < NUM_MSHR_B)
                         && !busy_vec[bus.req_mshrid[IDW-1:0]];
  assign req_fire      = bus.req_valid && bus.req_ready;
  assign noc1_fire     = bus.noc1_valid_out && bus.noc1_ready_out;
  assign bus.noc2_ready_in = !rst;
  assign noc2_fire     = bus.noc2_valid_in && bus.noc2_ready_in;
  assign first_pay     = (rx_cnt == rx_len);

  // TX flit sequencing; flit content is a function of state and latched fields so it holds under stall
  always_comb begin
    tx_next            = tx_state;
    bus.noc1_valid_out = 1'b0;
    bus.noc1_data_out  = '0;
    case (tx_state)
      IDLE: if (req_fire) tx_next = HDR;
      HDR: begin
        bus.noc1_valid_out = 1'b1;
        bus.noc1_data_out  = {dst_chipid, dst_x, dst_y, 4'd0, 8'd2, STORE_REQ_TYPE,
                              tx_id, tx_size, 3'd0};
        if (bus.noc1_ready_out) tx_next = ADDR;
      end
      ADDR: begin
        bus.noc1_valid_out = 1'b1;
        bus.noc1_data_out  = {24'd0, tx_addr};
        if (bus.noc1_ready_out) tx_next = SRC;
      end
      SRC: begin
        bus.noc1_valid_out = 1'b1;
        bus.noc1_data_out  = {src_chipid, src_x, src_y, 34'd0};
        if (bus.noc1_ready_out) tx_next = IDLE;
      end
      default: tx_next = IDLE;
    endcase
  end

  // TX state and request field capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= IDLE;
      tx_addr  <= '0;
      tx_id    <= '0;
      tx_size  <= '0;
    end else begin
      tx_state <= tx_next;
      if (req_fire) begin
        tx_addr <= bus.req_addr;
        tx_id   <= bus.req_mshrid;
        tx_size <= bus.req_size;
      end
    end
  end

  // Completion detection and match against outstanding slots
  always_comb begin
    cmp_fire = 1'b0;
    cmp_type = rx_type;
    cmp_id   = rx_id;
    cmp_len  = rx_len;
    cmp_data = rx_data;
    if (noc2_fire) begin
      if (rx_state == R_HDR) begin
        if (bus.noc2_data_in[29:22] == 8'd0) begin
          cmp_fire = 1'b1;
          cmp_type = bus.noc2_data_in[21:14];
          cmp_id   = bus.noc2_data_in[13:6];
          cmp_len  = 8'd0;
          cmp_data = '0;
        end
      end else begin
        if (first_pay) cmp_data = bus.noc2_data_in;
        if (rx_cnt == 8'd1) cmp_fire = 1'b1;
      end
    end
    cmp_err = (cmp_id >= NUM_MSHR_B) || !busy_vec[cmp_id[IDW-1:0]] || (cmp_len > MAX_PAYLOAD);
    set_vec = '0;
    clr_vec = '0;
    if (req_fire) set_vec[bus.req_mshrid[IDW-1:0]] = 1'b1;
    if (cmp_fire && !cmp_err) clr_vec[cmp_id[IDW-1:0]] = 1'b1;
  end

  // RX deserializer: header capture, payload count-down, first payload retained
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= R_HDR;
      rx_type  <= '0;
      rx_id    <= '0;
      rx_len   <= '0;
      rx_cnt   <= '0;
      rx_data  <= '0;
    end else if (noc2_fire) begin
      if (rx_state == R_HDR) begin
        rx_type <= bus.noc2_data_in[21:14];
        rx_id   <= bus.noc2_data_in[13:6];
        rx_len  <= bus.noc2_data_in[29:22];
        rx_cnt  <= bus.noc2_data_in[29:22];
        if (bus.noc2_data_in[29:22] != 8'd0) rx_state <= R_PAY;
      end else begin
        rx_cnt <= rx_cnt - 8'd1;
        if (first_pay) rx_data <= bus.noc2_data_in;
        if (rx_cnt == 8'd1) rx_state <= R_HDR;
      end
    end
  end

  // Completion report and outstanding-slot bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.resp_valid  <= 1'b0;
      bus.resp_type   <= '0;
      bus.resp_mshrid <= '0;
      bus.resp_data   <= '0;
      bus.resp_error  <= 1'b0;
      busy_vec        <= '0;
    end else begin
      bus.resp_valid <= cmp_fire;
      if (cmp_fire) begin
        bus.resp_type   <= cmp_type;
        bus.resp_mshrid <= cmp_id;
        bus.resp_data   <= cmp_data;
        bus.resp_error  <= cmp_err;
      end
      busy_vec <= (busy_vec & ~clr_vec) | set_vec;
    end
  end
endmodule

// File: tb/tb_l15_store_req_noc_if.sv
// tb/tb_l15_store_req_noc_if.sv - directed bench for the L1.5 store request NoC endpoint
module tb_l15_store_req_noc_if;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  localparam logic [13:0] DST_CHIP = 14'h0ABC;
  localparam logic [7:0]  DST_X    = 8'h11;
  localparam logic [7:0]  DST_Y    = 8'h22;
  localparam logic [13:0] SRC_CHIP = 14'h0123;
  localparam logic [7:0]  SRC_X    = 8'h33;
  localparam logic [7:0]  SRC_Y    = 8'h44;

  localparam logic [39:0] A1 = 40'h12_3456_7880;
  localparam logic [39:0] A2 = 40'h00_ABCD_E000;
  localparam logic [39:0] A3 = 40'h00_0000_0040;
  localparam logic [39:0] A4 = 40'hFF_0000_1000;
  localparam logic [39:0] A5 = 40'h0A_5A5A_5A00;
  localparam logic [63:0] P1 = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] P2 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] P3 = 64'hCAFE_F00D_0000_0001;

  l15_store_req_noc_if_if bus ();
  logic [7:0] busy_vec;

  l15_store_req_noc_if dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dst_chipid (DST_CHIP),
    .dst_x      (DST_X),
    .dst_y      (DST_Y),
    .src_chipid (SRC_CHIP),
    .src_x      (SRC_X),
    .src_y      (SRC_Y),
    .busy_vec   (busy_vec)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] hdr_flit(input logic [7:0] id, input logic [2:0] size);
    return {DST_CHIP, DST_X, DST_Y, 4'd0, 8'd2, 8'd2, id, size, 3'd0};
  endfunction

  function automatic logic [63:0] src_flit();
    return {SRC_CHIP, SRC_X, SRC_Y, 34'd0};
  endfunction

  function automatic logic [63:0] n2_hdr(input logic [7:0] len, input logic [7:0] typ,
                                         input logic [7:0] id);
    return {34'd0, len, typ, id, 6'd0};
  endfunction

  // One NoC2 flit presented for exactly one clock edge
  task automatic send_n2(input logic [63:0] flit);
    bus.noc2_valid_in = 1'b1;
    bus.noc2_data_in  = flit;
    @(negedge clk);
    bus.noc2_valid_in = 1'b0;
  endtask

  // Offer a request and withdraw it right after the accepting edge
  task automatic issue(input logic [7:0] id, input logic [39:0] addr, input logic [2:0] size);
    bus.req_valid  = 1'b1;
    bus.req_mshrid = id;
    bus.req_addr   = addr;
    bus.req_size   = size;
    #1 chk("req_ready_offer", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_flit(input string tag, input logic [63:0] exp);
    chk({tag, "_valid"}, 64'(bus.noc1_valid_out), 64'd1);
    chk({tag, "_data"}, bus.noc1_data_out, exp);
  endtask

  initial begin
    bus.req_valid      = 1'b1;
    bus.req_addr       = '0;
    bus.req_mshrid     = 8'd0;
    bus.req_size       = 3'd0;
    bus.noc1_ready_out = 1'b1;
    bus.noc2_valid_in  = 1'b0;
    bus.noc2_data_in   = '0;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_noc1_valid", 64'(bus.noc1_valid_out), 64'd0);
    chk("rst_noc1_data", bus.noc1_data_out, 64'd0);
    chk("rst_noc2_ready", 64'(bus.noc2_ready_in), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_busy", 64'(busy_vec), 64'd0);
    bus.req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("noc2_ready_run", 64'(bus.noc2_ready_in), 64'd1);

    // Single store, full-speed NoC1
    issue(8'd3, A1, 3'd3);
    chk_flit("s1_hdr", hdr_flit(8'd3, 3'd3));
    chk("s1_busy", 64'(busy_vec), 64'h08);
    @(negedge clk);
    chk_flit("s1_addr", {24'd0, A1});
    @(negedge clk);
    chk_flit("s1_src", src_flit());
    @(negedge clk);
    chk("s1_idle", 64'(bus.noc1_valid_out), 64'd0);

    // Backpressure on the ADDR flit
    issue(8'd2, A2, 3'd1);
    chk_flit("bp_hdr", hdr_flit(8'd2, 3'd1));
    @(negedge clk);
    chk_flit("bp_addr", {24'd0, A2});
    bus.noc1_ready_out = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_flit("bp_hold", {24'd0, A2});
    end
    bus.noc1_ready_out = 1'b1;
    @(negedge clk);
    chk_flit("bp_src", src_flit());
    @(negedge clk);
    chk("bp_idle", 64'(bus.noc1_valid_out), 64'd0);
    chk("bp_busy", 64'(busy_vec), 64'h0C);

    // Zero-length ack for id 3
    send_n2(n2_hdr(8'd0, 8'd14, 8'd3));
    chk("ack3_valid", 64'(bus.resp_valid), 64'd1);
    chk("ack3_type", 64'(bus.resp_type), 64'd14);
    chk("ack3_id", 64'(bus.resp_mshrid), 64'd3);
    chk("ack3_err", 64'(bus.resp_error), 64'd0);
    chk("ack3_data", bus.resp_data, 64'd0);
    chk("ack3_busy", 64'(busy_vec), 64'h04);
    @(negedge clk);
    chk("ack3_pulse_end", 64'(bus.resp_valid), 64'd0);
    chk("ack3_type_hold", 64'(bus.resp_type), 64'd14);

    // Two-flit payload for an id that is not outstanding
    send_n2(n2_hdr(8'd2, 8'd7, 8'd5));
    chk("un5_no_early_hdr", 64'(bus.resp_valid), 64'd0);
    send_n2(P1);
    chk("un5_no_early_pay", 64'(bus.resp_valid), 64'd0);
    send_n2(P2);
    chk("un5_valid", 64'(bus.resp_valid), 64'd1);
    chk("un5_err", 64'(bus.resp_error), 64'd1);
    chk("un5_data", bus.resp_data, P1);
    chk("un5_id", 64'(bus.resp_mshrid), 64'd5);
    chk("un5_busy", 64'(busy_vec), 64'h04);

    // One-flit payload completes id 2
    send_n2(n2_hdr(8'd1, 8'd3, 8'd2));
    send_n2(P3);
    chk("r2_valid", 64'(bus.resp_valid), 64'd1);
    chk("r2_err", 64'(bus.resp_error), 64'd0);
    chk("r2_data", bus.resp_data, P3);
    chk("r2_busy", 64'(busy_vec), 64'h00);

    // Busy id blocks a second request until completion
    issue(8'd1, A3, 3'd2);
    repeat (3) @(negedge clk);
    bus.req_mshrid = 8'd1;
    #1 chk("busy1_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    chk("busy1_ready_idle", 64'(bus.req_ready), 64'd0);
    bus.req_mshrid = 8'd8;
    #1 chk("id8_ready", 64'(bus.req_ready), 64'd0);
    bus.req_mshrid = 8'd1;
    send_n2(n2_hdr(8'd0, 8'd14, 8'd1));
    chk("busy1_ready_after", 64'(bus.req_ready), 64'd1);
    chk("busy1_clear", 64'(busy_vec), 64'h00);

    // Same-edge set and completion for id 0, which is not yet busy
    bus.req_valid     = 1'b1;
    bus.req_mshrid    = 8'd0;
    bus.req_addr      = A3;
    bus.req_size      = 3'd2;
    bus.noc2_valid_in = 1'b1;
    bus.noc2_data_in  = n2_hdr(8'd0, 8'd14, 8'd0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    bus.noc2_valid_in = 1'b0;
    @(negedge clk);
    chk("sim0_valid", 64'(bus.resp_valid), 64'd1);
    chk("sim0_err", 64'(bus.resp_error), 64'd1);
    chk("sim0_busy", 64'(busy_vec), 64'h01);
    chk_flit("sim0_hdr", hdr_flit(8'd0, 3'd2));
    repeat (3) @(negedge clk);
    send_n2(n2_hdr(8'd0, 8'd14, 8'd0));
    chk("sim0_clear_err", 64'(bus.resp_error), 64'd0);
    chk("sim0_clear_busy", 64'(busy_vec), 64'h00);

    // Reset in the middle of a message
    issue(8'd4, A4, 3'd0);
    @(negedge clk);
    chk_flit("mr_addr", {24'd0, A4});
    bus.req_valid  = 1'b1;
    bus.req_mshrid = 8'd6;
    #2 rst = 1'b1;
    #1 chk("mr_valid", 64'(bus.noc1_valid_out), 64'd0);
    chk("mr_data", bus.noc1_data_out, 64'd0);
    chk("mr_busy", 64'(busy_vec), 64'h00);
    chk("mr_req_ready", 64'(bus.req_ready), 64'd0);
    chk("mr_resp_valid", 64'(bus.resp_valid), 64'd0);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(8'd6, A5, 3'd5);
    chk_flit("mr_next_hdr", hdr_flit(8'd6, 3'd5));
    chk("mr_next_busy", 64'(busy_vec), 64'h40);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
